// File: rtl/wb_pkg.sv
// Shared writeback types and widths for the register-file write arbiter.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending accelerator writebacks; head is visible combinationally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  wb_req_t                  i_push_data,
  input  logic                     i_pop,
  output wb_req_t                  o_head_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Overflow and underflow requests are dropped rather than corrupting state.
  assign w_push = i_push && !o_full_c;
  assign w_pop  = i_pop && !o_empty_c;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes always win, buffered
// accelerator results drain in idle slots, and long starvation requests a stall.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_wb_valid,
  input  logic [4:0]                    pipe_wb_rd,
  input  logic [31:0]                   pipe_wb_data,
  input  logic                          acc_wb_valid,
  output logic                          acc_wb_ready,
  input  logic [4:0]                    acc_wb_rd,
  input  logic [31:0]                   acc_wb_data,
  output logic                          rf_write_en,
  output logic [4:0]                    rf_rd,
  output logic [31:0]                   rf_data,
  output logic                          stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned ST_W = $clog2(STARVE_LIMIT + 1);

  logic                    w_pipe_req;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  wb_req_t                 w_head;
  wb_req_t                 w_acc_req;
  logic [ST_W-1:0]         w_starve_next;

  logic [ST_W-1:0]         r_starve;
  logic                    r_stall_req;
  logic                    r_rf_write_en;
  logic [REG_ADDR_W-1:0]   r_rf_rd;
  logic [XLEN-1:0]         r_rf_data;

  // Writes to x0 are architecturally void, so they never claim the port or a slot.
  assign w_pipe_req   = pipe_wb_valid && (pipe_wb_rd != '0);
  assign acc_wb_ready = !w_full;
  assign w_push       = acc_wb_valid && acc_wb_ready && (acc_wb_rd != '0);
  assign w_pop        = !w_pipe_req && !w_empty;
  assign w_acc_req    = '{rd: acc_wb_rd, data: acc_wb_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_acc_req),
    .i_pop       (w_pop),
    .o_head_c    (w_head),
    .o_full_c    (w_full),
    .o_empty_c   (w_empty),
    .o_count     (fifo_count)
  );

  // Starvation only accrues while a pending entry is held off by the pipeline.
  always_comb begin
    w_starve_next = r_starve;
    if (w_empty || w_pop) begin
      w_starve_next = '0;
    end else if (w_pipe_req && (r_starve != ST_W'(STARVE_LIMIT))) begin
      w_starve_next = r_starve + ST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve    <= '0;
      r_stall_req <= 1'b0;
    end else begin
      r_starve    <= w_starve_next;
      r_stall_req <= (w_starve_next == ST_W'(STARVE_LIMIT));
    end
  end

  // Address and data hold their last value when no write occurs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_write_en <= 1'b0;
      r_rf_rd       <= '0;
      r_rf_data     <= '0;
    end else if (w_pipe_req) begin
      r_rf_write_en <= 1'b1;
      r_rf_rd       <= pipe_wb_rd;
      r_rf_data     <= pipe_wb_data;
    end else if (w_pop) begin
      r_rf_write_en <= 1'b1;
      r_rf_rd       <= w_head.rd;
      r_rf_data     <= w_head.data;
    end else begin
      r_rf_write_en <= 1'b0;
    end
  end

  assign rf_write_en = r_rf_write_en;
  assign rf_rd       = r_rf_rd;
  assign rf_data     = r_rf_data;
  assign stall_req   = r_stall_req;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table plus starvation and reset sequences.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        acc_wb_valid;
  logic        acc_wb_ready;
  logic [4:0]  acc_wb_rd;
  logic [31:0] acc_wb_data;
  logic        rf_write_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        stall_req;
  logic [2:0]  fifo_count;

  int checks;
  int failures;

  wb_arbiter #(
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_rd    (pipe_wb_rd),
    .pipe_wb_data  (pipe_wb_data),
    .acc_wb_valid  (acc_wb_valid),
    .acc_wb_ready  (acc_wb_ready),
    .acc_wb_rd     (acc_wb_rd),
    .acc_wb_data   (acc_wb_data),
    .rf_write_en   (rf_write_en),
    .rf_rd         (rf_rd),
    .rf_data       (rf_data),
    .stall_req     (stall_req),
    .fifo_count    (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        rdy;
    logic        st;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                              input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic en, input logic [4:0] rd, input logic [31:0] data,
                              input logic [2:0] cnt, input logic rdy, input logic st);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.av = av; v.ard = ard; v.ad = ad;
    v.en = en; v.rd = rd; v.data = data; v.cnt = cnt; v.rdy = rdy; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    pipe_wb_valid = pv; pipe_wb_rd = prd; pipe_wb_data = pd;
    acc_wb_valid = av;  acc_wb_rd = ard;  acc_wb_data = ad;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic en, input logic [4:0] rd,
                           input logic [31:0] data, input logic [2:0] cnt,
                           input logic rdy, input logic st);
    check({tag, ".en"},    32'(rf_write_en),  32'(en));
    check({tag, ".rd"},    32'(rf_rd),        32'(rd));
    check({tag, ".data"},  rf_data,           data);
    check({tag, ".count"}, 32'(fifo_count),   32'(cnt));
    check({tag, ".ready"}, 32'(acc_wb_ready), 32'(rdy));
    check({tag, ".stall"}, 32'(stall_req),    32'(st));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //                pv  prd   pd            av  ard    ad            en  rd     data          cnt  rdy st
    vecs[0]  = mk(1, 5'd5, 32'h01114444, 0, 5'd0,  32'h0,        1, 5'd5,  32'h01114444, 3'd0, 1, 0);
    vecs[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd5,  32'h01114444, 3'd0, 1, 0);
    vecs[2]  = mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'h0,        0, 5'd5,  32'h01114444, 3'd0, 1, 0);
    vecs[3]  = mk(0, 5'd0, 32'h0,        1, 5'd7,  32'hDEADBEEF, 0, 5'd5,  32'h01114444, 3'd1, 1, 0);
    vecs[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  32'hDEADBEEF, 3'd0, 1, 0);
    vecs[5]  = mk(0, 5'd0, 32'h0,        1, 5'd0,  32'h12345678, 0, 5'd7,  32'hDEADBEEF, 3'd0, 1, 0);
    vecs[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd7,  32'hDEADBEEF, 3'd0, 1, 0);
    vecs[7]  = mk(1, 5'd1, 32'h00000001, 1, 5'd10, 32'h000000A0, 1, 5'd1,  32'h00000001, 3'd1, 1, 0);
    vecs[8]  = mk(1, 5'd2, 32'h00000002, 1, 5'd11, 32'h000000A1, 1, 5'd2,  32'h00000002, 3'd2, 1, 0);
    vecs[9]  = mk(1, 5'd3, 32'h00000003, 1, 5'd12, 32'h000000A2, 1, 5'd3,  32'h00000003, 3'd3, 1, 0);
    vecs[10] = mk(1, 5'd4, 32'h00000004, 1, 5'd13, 32'h000000A3, 1, 5'd4,  32'h00000004, 3'd4, 0, 0);
    vecs[11] = mk(1, 5'd5, 32'h00000005, 1, 5'd14, 32'h000000A4, 1, 5'd5,  32'h00000005, 3'd4, 0, 0);
    vecs[12] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd10, 32'h000000A0, 3'd3, 1, 0);
    vecs[13] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd11, 32'h000000A1, 3'd2, 1, 0);
    vecs[14] = mk(0, 5'd0, 32'h0,        1, 5'd15, 32'h000000B0, 1, 5'd12, 32'h000000A2, 3'd2, 1, 0);
    vecs[15] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd13, 32'h000000A3, 3'd1, 1, 0);
    vecs[16] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd15, 32'h000000B0, 3'd0, 1, 0);
    vecs[17] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd15, 32'h000000B0, 3'd0, 1, 0);

    reset = 1'b1;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    step();
    step();
    check_all("reset", 0, 5'd0, 32'h0, 3'd0, 1, 0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].av, vecs[i].ard, vecs[i].ad);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].rd, vecs[i].data,
                vecs[i].cnt, vecs[i].rdy, vecs[i].st);
    end

    // Starvation: one pending entry blocked by a busy pipeline.
    drive(0, 5'd0, 32'h0, 1, 5'd20, 32'h000000C0);
    step();
    check_all("starve_fill", 0, 5'd15, 32'h000000B0, 3'd1, 1, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 5'd2, 32'h00000022, 0, 5'd0, 32'h0);
      step();
      check_all($sformatf("starve%0d", i + 1), 1, 5'd2, 32'h00000022, 3'd1, 1, (i >= 7));
    end
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    step();
    check_all("starve_drain", 1, 5'd20, 32'h000000C0, 3'd0, 1, 0);

    // Reset with three buffered entries must flush them unwritten.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd3, 32'h00000033, 1, 5'(21 + i), 32'hD0 + 32'(i));
      step();
    end
    check("flush_pre.count", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    drive(1, 5'd9, 32'h00000099, 1, 5'd24, 32'h000000E0);
    step();
    check_all("flush_rst", 0, 5'd0, 32'h0, 3'd0, 1, 0);
    reset = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_all($sformatf("flush_post%0d", i), 0, 5'd0, 32'h0, 3'd0, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning accelerator-result buffer entries (power of two, >=2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive blocked-drain cycles before a stall is requested.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port pipe_wb_valid  input  1  core pipeline writeback request, cannot be back-pressured.
REQ-006 The block SHALL have port pipe_wb_rd  input  5  pipeline destination register.
REQ-007 The block SHALL have port pipe_wb_data  input  32  pipeline writeback data.
REQ-008 The block SHALL have port acc_wb_valid  input  1  accelerator/load result valid.
REQ-009 The block SHALL have port acc_wb_ready  output  1  buffer can accept a result.
REQ-010 The block SHALL have port acc_wb_rd  input  5  accelerator destination register.
REQ-011 The block SHALL have port acc_wb_data  input  32  accelerator result data.
REQ-012 The block SHALL have port rf_write_en  output  1  register-file write enable.
REQ-013 The block SHALL have port rf_rd  output  5  register-file write address.
REQ-014 The block SHALL have port rf_data  output  32  register-file write data.
REQ-015 The block SHALL have port stall_req  output  1  request to pipeline to insert writeback bubbles.
REQ-016 The block SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  buffered entries.

Function
REQ-017 rf_write_en/rf_rd/rf_data SHALL be registered; pipeline write at edge N appears on rf_* during cycle N+1 (latency 1).
REQ-018 A pipeline request with pipe_wb_rd==0 SHALL be treated as no request.
REQ-019 Pipeline writes SHALL always win; the buffer head SHALL drain only in a cycle with no effective pipeline request.
REQ-020 acc_wb_ready SHALL equal (fifo_count < FIFO_DEPTH), combinational from count only, no pass-through when full.
REQ-021 A transfer SHALL occur when acc_wb_valid && acc_wb_ready; results with acc_wb_rd==0 SHALL be accepted and discarded (not enqueued).
REQ-022 An enqueued result SHALL reach rf_* no earlier than two cycles after acceptance (enqueue edge, drain edge).
REQ-023 Simultaneous enqueue and drain SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-024 With no pipeline request and an empty buffer, rf_write_en SHALL be 0 in the following cycle; rf_rd/rf_data hold last values.
REQ-025 A starve counter SHALL increment each cycle the buffer is non-empty and a pipeline request blocks drain, clear on any drain or empty buffer, and saturate at STARVE_LIMIT.
REQ-026 stall_req SHALL be registered, asserted while starve counter == STARVE_LIMIT, and deassert the cycle after the next drain.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-028 While reset is high at an edge: rf_write_en=0, rf_rd=0, rf_data=0, stall_req=0, fifo_count=0, pointers and starve counter=0.
REQ-029 Reset mid-operation SHALL flush all buffered results without writing them; acc_wb_ready SHALL be 1 in the cycle after reset deasserts.
REQ-030 Inputs during reset SHALL be ignored (no enqueue, no write).

Structure
REQ-031 Shared package wb_pkg SHALL hold XLEN=32, REG_ADDR_W=5 and packed struct wb_req_t {rd, data}.
REQ-032 Buffer SHALL be a separate sub-module wb_fifo (parameterised depth, push/pop/full/empty/count); arbitration and starve logic in wb_arbiter.

Verification
REQ-033 Pipe-only: pipe rd=5 data=32'h01114444 at edge N -> rf_write_en=1, rf_rd=5, rf_data=32'h01114444 in cycle N+1.
REQ-034 Acc-only idle pipe: acc rd=7 data=32'hDEADBEEF accepted at N -> rf write of x7 in cycle N+2; rd=0 result -> no write, count stays 0.
REQ-035 Fill: four acc results with pipe continuously valid -> acc_wb_ready=0 after 4th, fifo_count=4; after pipe idles, drains in order, one per cycle.
REQ-036 Starvation: buffer non-empty, pipe valid (rd!=0) 8 cycles -> stall_req=1; one idle pipe cycle -> drain and stall_req=0 next cycle.
REQ-037 Reset with fifo_count=3 -> no rf writes of those entries, count=0, acc_wb_ready=1 after release.
REQ-038 Simultaneous enqueue+drain at count=2 -> count stays 2, order preserved.
